// File: rtl/hs_fifo_pkg.sv
// Shared types and helpers for the hs_fifo command slave and its response FIFO.
package hs_fifo_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  // One extra pointer bit distinguishes full from empty when the indices match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_fifo_sync_fifo.sv
// Response FIFO: registered storage, wrap-bit pointers, head entry visible combinationally.
module sync_fifo
  import hs_fifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int PTR_WD = ptr_width(DEPTH);
  localparam int IDX_WD = PTR_WD - 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_WD-1] != rd_ptr_q[PTR_WD-1]) &&
                   (wr_ptr_q[IDX_WD-1:0] == rd_ptr_q[IDX_WD-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[IDX_WD-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_WD'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_WD'(1);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[IDX_WD-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/hs_fifo.sv
// Valid/ready command slave over a small register-file memory; reads are returned
// in order through a response FIFO on a valid/ready output channel.
module hs_fifo
  import hs_fifo_pkg::*;
#(
  parameter int DATA_WD    = 4,
  parameter int ADDR_WD    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               valid_in,
  input  logic               cmd_in,
  input  logic [ADDR_WD-1:0] addr_in,
  input  logic [DATA_WD-1:0] data_in,
  input  logic               ready_out,
  output logic               ready_in,
  output logic               valid_out,
  output logic [DATA_WD-1:0] data_out
);

  localparam int MEM_DEPTH = 2 ** ADDR_WD;

  logic [DATA_WD-1:0] mem_q [MEM_DEPTH];
  logic               fire_in, fire_out;
  logic               wr_en, rd_en;
  logic               fifo_full, fifo_empty;
  logic [DATA_WD-1:0] fifo_head;

  // ready_in depends only on FIFO state, so writes also stall while full.
  assign ready_in  = !fifo_full;
  assign valid_out = !fifo_empty;
  assign data_out  = valid_out ? fifo_head : '0;
  assign fire_in   = valid_in && ready_in;
  assign fire_out  = valid_out && ready_out;
  assign wr_en     = fire_in && (cmd_e'(cmd_in) == CMD_WRITE);
  assign rd_en     = fire_in && (cmd_e'(cmd_in) == CMD_READ);

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[addr_in] <= data_in;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rd_en),
    .pop_i   (fire_out),
    .din_i   (mem_q[addr_in]),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_head)
  );

endmodule

// File: tb/tb_hs_fifo.sv
// Scoreboard bench for hs_fifo: stimulus pushes expected read data, a monitor pops on fire_out.
module tb_hs_fifo;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid_in;
  logic       cmd_in;
  logic [3:0] addr_in;
  logic [3:0] data_in;
  logic       ready_out;
  logic       ready_in;
  logic       valid_out;
  logic [3:0] data_out;

  int         checks = 0;
  int         failures = 0;
  int         resp_cnt = 0;
  int         reads_issued = 0;
  logic [3:0] exp_q[$];
  logic [3:0] model_mem [16];
  logic [3:0] e;
  logic       p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
  logic [3:0] p_data = '0;

  always #5 clk = ~clk;

  hs_fifo #(.DATA_WD(4), .ADDR_WD(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .cmd_in    (cmd_in),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  // Monitor: compares every response the DUT hands over, plus hold/stability rules.
  always @(negedge clk) begin
    if (valid_out && ready_out) begin
      checks++;
      resp_cnt++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected got=%0h exp=none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL resp_data got=%0h exp=%0h", data_out, e);
        end
      end
    end
    if (p_valid && !p_ready && !p_rst) begin
      checks++;
      if (valid_out !== 1'b1 || data_out !== p_data) begin
        failures++;
        $display("FAIL resp_hold got=%0b/%0h exp=1/%0h", valid_out, data_out, p_data);
      end
    end
    p_valid = valid_out;
    p_ready = ready_out;
    p_data  = data_out;
    p_rst   = rstn;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
  endtask

  task automatic record(input logic c, input logic [3:0] a, input logic [3:0] d);
    if (c) model_mem[a] = d;
    else begin
      exp_q.push_back(model_mem[a]);
      reads_issued++;
    end
  endtask

  // Drives one command and holds it until accepted; returns how many cycles it stalled.
  task automatic send(input logic c, input logic [3:0] a, input logic [3:0] d, output int waits);
    valid_in = 1'b1;
    cmd_in   = c;
    addr_in  = a;
    data_in  = d;
    waits    = 0;
    @(negedge clk);
    while (!ready_in && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!ready_in) begin
      failures++;
      $display("FAIL send_timeout got=ready_in0 exp=ready_in1 addr=%0h", a);
    end else begin
      record(c, a, d);
    end
    sync();
    valid_in = 1'b0;
    cmd_in   = 1'bx;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !valid_out) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || valid_out) begin
      failures++;
      $display("FAIL drain_timeout got=%0d_pending exp=0", exp_q.size());
    end
    sync();
  endtask

  initial begin
    int w;
    int n;
    int cyc;
    rstn      = 1'b1;
    valid_in  = 1'b0;
    cmd_in    = 1'b0;
    addr_in   = '0;
    data_in   = '0;
    ready_out = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    sync();

    // Read right after reset returns cleared memory, one cycle after fire.
    ready_out = 1'b1;
    send(1'b0, 4'd7, 4'd0, w);
    @(negedge clk);
    chk("rd_latency_valid", 32'(valid_out), 32'd1);
    chk("rd_after_rst_data", 32'(data_out), 32'd0);
    sync();
    wait_drain();

    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 4'(i), w);
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 4'd0, w);
    wait_drain();

    // Backpressure: four reads fill the FIFO, the fifth stalls until the first pop.
    ready_out = 1'b0;
    for (int i = 3; i <= 6; i++) send(1'b0, 4'(i), 4'd0, w);
    @(negedge clk);
    chk("full_ready_in", 32'(ready_in), 32'd0);
    chk("full_valid_out", 32'(valid_out), 32'd1);
    chk("full_head", 32'(data_out), 32'd3);
    sync();
    valid_in = 1'b1;
    cmd_in   = 1'b0;
    addr_in  = 4'd7;
    @(negedge clk);
    chk("full_blocks_5th", 32'(ready_in), 32'd0);
    sync();
    ready_out = 1'b1;
    send(1'b0, 4'd7, 4'd0, w);
    chk("5th_after_one_pop", 32'(w), 32'd1);
    wait_drain();

    // Simultaneous push and pop with two entries queued keeps the count at two.
    ready_out = 1'b0;
    send(1'b0, 4'd1, 4'd0, w);
    send(1'b0, 4'd2, 4'd0, w);
    ready_out = 1'b1;
    send(1'b0, 4'd8, 4'd0, w);
    ready_out = 1'b0;
    @(negedge clk);
    chk("pushpop_valid", 32'(valid_out), 32'd1);
    chk("pushpop_head", 32'(data_out), 32'd2);
    chk("pushpop_ready_in", 32'(ready_in), 32'd1);
    sync();
    send(1'b0, 4'd10, 4'd0, w);
    send(1'b0, 4'd11, 4'd0, w);
    @(negedge clk);
    chk("pushpop_count2_full", 32'(ready_in), 32'd0);
    sync();
    ready_out = 1'b1;
    wait_drain();

    // Read-after-write, then reset with responses queued.
    send(1'b1, 4'd9, 4'hA, w);
    send(1'b0, 4'd9, 4'd0, w);
    wait_drain();
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 4'd9, 4'd0, w);
    rstn = 1'b1;
    exp_q.delete();
    reads_issued = reads_issued - 3;
    model_clear();
    sync();
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_ready_in", 32'(ready_in), 32'd1);
    sync();
    ready_out = 1'b1;
    send(1'b0, 4'd9, 4'd0, w);
    @(negedge clk);
    chk("midrst_mem_cleared", 32'(data_out), 32'd0);
    sync();
    wait_drain();

    // Random handshakes: 16 writes then 16 reads, addr = data = command index.
    n = 0;
    cyc = 0;
    while (cyc < 400 && (cyc < 100 || n < 32)) begin
      valid_in  = (n < 32) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_in    = (n < 16);
      addr_in   = 4'(n);
      data_in   = 4'(n);
      ready_out = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (valid_in && ready_in) begin
        record(cmd_in, addr_in, data_in);
        n++;
      end
      sync();
      cyc++;
    end
    valid_in = 1'b0;
    chk("rand_all_issued", 32'(n), 32'd32);
    ready_out = 1'b1;
    wait_drain();

    chk("no_pending", 32'(exp_q.size()), 32'd0);
    chk("resp_count", 32'(resp_cnt), 32'(reads_issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
